// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs_driver: ap_ctrl_hs initiator issuing a programmed number of kernel
// transactions, tracking outstanding starts and start-to-done latency.
module ap_ctrl_hs_driver #(
   parameter int TXN_W   = 16,
   parameter int LAT_W   = 32,
   parameter int MAX_OUT = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cfg_start_i,
   input  logic [TXN_W-1:0] cfg_num_txn_i,
   input  logic [7:0]       cfg_gap_i,
   output logic             ap_start_o,
   input  logic             ap_ready_i,
   input  logic             ap_done_i,
   output logic             ap_continue_o,
   output logic             busy_o,
   output logic             finish_o,
   output logic [TXN_W-1:0] txn_issued_o,
   output logic [TXN_W-1:0] txn_done_o,
   output logic [LAT_W-1:0] lat_last_o,
   output logic [LAT_W-1:0] lat_min_o,
   output logic [LAT_W-1:0] lat_max_o,
   output logic             err_spurious_o,
   output logic             err_timeout_o
);
   localparam int PW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW   = $clog2(MAX_OUT + 1);
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]   MAX_C = CW'(MAX_OUT);
   localparam logic [WD_W-1:0] TO_C  = WD_W'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, FINISH} state_t;

   state_t           state_q, state_d;
   logic [TXN_W-1:0] num_q, num_d, issued_q, issued_d, done_q, done_d;
   logic [7:0]       gap_q, gap_d, gcnt_q, gcnt_d;
   logic [LAT_W-1:0] cyc_q, ts_q, ts_d, last_q, last_d, min_q, min_d, max_q, max_d;
   logic [LAT_W-1:0] cur_ts, lat;
   logic [LAT_W-1:0] mem_q [MAX_OUT];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             tsv_q, tsv_d, esp_q, esp_d, eto_q, eto_d, fin_q, fin_d, cont_q;
   logic             push, pop, wen, ren;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   assign ap_start_o     = (state_q == ISSUE) && (cnt_q < MAX_C);
   assign busy_o         = (state_q == ISSUE) || (state_q == GAP) || (state_q == DRAIN);
   assign ap_continue_o  = cont_q;
   assign finish_o       = fin_q;
   assign txn_issued_o   = issued_q;
   assign txn_done_o     = done_q;
   assign lat_last_o     = last_q;
   assign lat_min_o      = min_q;
   assign lat_max_o      = max_q;
   assign err_spurious_o = esp_q;
   assign err_timeout_o  = eto_q;

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      gap_d    = gap_q;
      gcnt_d   = gcnt_q;
      issued_d = issued_q;
      done_d   = done_q;
      last_d   = last_q;
      min_d    = min_q;
      max_d    = max_q;
      esp_d    = esp_q;
      eto_d    = eto_q;
      fin_d    = fin_q;
      wd_d     = wd_q;
      lat      = '0;
      pop      = 1'b0;
      push     = ap_start_o & ap_ready_i;
      cur_ts   = tsv_q ? ts_q : cyc_q;
      // a waiting start keeps the timestamp of its first asserted cycle
      tsv_d    = ap_start_o & ~ap_ready_i;
      ts_d     = (ap_start_o & ~tsv_q) ? cyc_q : ts_q;
      case (state_q)
         IDLE: if (cfg_start_i) begin
            num_d    = cfg_num_txn_i;
            gap_d    = cfg_gap_i;
            issued_d = '0;
            done_d   = '0;
            last_d   = '0;
            min_d    = '1;
            max_d    = '0;
            esp_d    = 1'b0;
            eto_d    = 1'b0;
            fin_d    = 1'b0;
            wd_d     = '0;
            state_d  = (cfg_num_txn_i == '0) ? FINISH : ISSUE;
         end
         ISSUE: if (push) begin
            issued_d = issued_q + 1'b1;
            gcnt_d   = gap_q;
            state_d  = (issued_d == num_q) ? DRAIN : (gap_q != 8'd0) ? GAP : ISSUE;
         end
         GAP: begin
            gcnt_d  = gcnt_q - 8'd1;
            state_d = (gcnt_q == 8'd1) ? ISSUE : GAP;
         end
         DRAIN: state_d = (done_q == num_q) ? FINISH : DRAIN;
         FINISH: begin
            fin_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (ap_done_i) begin
         if (cnt_q != '0 || push) begin
            pop    = 1'b1;
            lat    = cyc_q - ((cnt_q != '0) ? mem_q[rd_q] : cur_ts);
            done_d = done_d + 1'b1;
            last_d = lat;
            min_d  = (lat < min_d) ? lat : min_d;
            max_d  = (lat > max_d) ? lat : max_d;
         end else begin
            esp_d = 1'b1;
         end
      end
      // a done that finds the FIFO empty consumes the start it arrives with
      wen   = push & ~(pop & (cnt_q == '0));
      ren   = pop & (cnt_q != '0);
      wr_d  = wen ? nxt(wr_q) : wr_q;
      rd_d  = ren ? nxt(rd_q) : rd_q;
      cnt_d = cnt_q + CW'(wen) - CW'(ren);
      if (TIMEOUT != 0 && busy_o) begin
         wd_d = (ap_ready_i | ap_done_i) ? '0 : wd_q + 1'b1;
         if (wd_d == TO_C) begin
            eto_d   = 1'b1;
            state_d = FINISH;
            wd_d    = '0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         num_q    <= '0;
         gap_q    <= '0;
         gcnt_q   <= '0;
         issued_q <= '0;
         done_q   <= '0;
         cyc_q    <= '0;
         ts_q     <= '0;
         tsv_q    <= 1'b0;
         last_q   <= '0;
         min_q    <= '1;
         max_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         wd_q     <= '0;
         esp_q    <= 1'b0;
         eto_q    <= 1'b0;
         fin_q    <= 1'b0;
         cont_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         gap_q    <= gap_d;
         gcnt_q   <= gcnt_d;
         issued_q <= issued_d;
         done_q   <= done_d;
         cyc_q    <= cyc_q + 1'b1;
         ts_q     <= ts_d;
         tsv_q    <= tsv_d;
         last_q   <= last_d;
         min_q    <= min_d;
         max_q    <= max_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         wd_q     <= wd_d;
         esp_q    <= esp_d;
         eto_q    <= eto_d;
         fin_q    <= fin_d;
         cont_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wen) mem_q[wr_q] <= cur_ts;
   end
endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// tb_ap_ctrl_hs_driver: drives the handshake driver with a behavioural in-order
// kernel and checks counts, latencies, gaps and error flags against it.
module tb_ap_ctrl_hs_driver;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        cfg_start_i = 1'b0;
   logic [15:0] cfg_num_txn_i = '0;
   logic [7:0]  cfg_gap_i = '0;
   logic        ap_ready_i = 1'b0;
   logic        ap_done_i = 1'b0;
   logic        ap_start_o, ap_continue_o, busy_o, finish_o, err_spurious_o, err_timeout_o;
   logic [15:0] txn_issued_o, txn_done_o;
   logic [31:0] lat_last_o, lat_min_o, lat_max_o;

   ap_ctrl_hs_driver #(.TXN_W(16), .LAT_W(32), .MAX_OUT(4), .TIMEOUT(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .cfg_start_i(cfg_start_i),
      .cfg_num_txn_i(cfg_num_txn_i), .cfg_gap_i(cfg_gap_i),
      .ap_start_o(ap_start_o), .ap_ready_i(ap_ready_i), .ap_done_i(ap_done_i),
      .ap_continue_o(ap_continue_o), .busy_o(busy_o), .finish_o(finish_o),
      .txn_issued_o(txn_issued_o), .txn_done_o(txn_done_o),
      .lat_last_o(lat_last_o), .lat_min_o(lat_min_o), .lat_max_o(lat_max_o),
      .err_spurious_o(err_spurious_o), .err_timeout_o(err_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   int tcyc = 0;
   int pend[$];
   int wcnt, rdy_dly, lat_lo, lat_hi, zr, gmin, gmax, outst, maxo, drop_err, started;
   bit waiting, after_rdy;
   longint emin, emax, elast;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_clear(input int rdy, input int lo, input int hi);
      wcnt = 0; rdy_dly = rdy; lat_lo = lo; lat_hi = hi;
      waiting = 0; after_rdy = 0; zr = 0; gmin = 1000; gmax = -1;
      outst = 0; maxo = 0; drop_err = 0; started = 0;
      emin = 64'hFFFF_FFFF; emax = 0; elast = 0;
   endtask

   // one cycle of the in-order kernel: answer the start/ready handshake and emit dones
   task automatic step();
      int s, dt, l;
      @(negedge clk_i);
      tcyc++;
      if (waiting && !ap_start_o) drop_err++;
      if (after_rdy) begin
         if (ap_start_o) begin
            gmin = (zr < gmin) ? zr : gmin;
            gmax = (zr > gmax) ? zr : gmax;
            after_rdy = 0;
         end else zr++;
      end
      if (ap_start_o) started++;
      ap_done_i = (pend.size() != 0 && pend[0] == tcyc);
      if (ap_done_i) begin
         void'(pend.pop_front());
         outst--;
      end
      ap_ready_i = 1'b0;
      waiting = 0;
      if (ap_start_o) begin
         if (wcnt >= rdy_dly) begin
            ap_ready_i = 1'b1;
            s = tcyc - wcnt;
            dt = s + int'($urandom_range(lat_hi, lat_lo));
            if (dt <= tcyc) dt = tcyc + 1;
            if (pend.size() != 0 && dt <= pend[$]) dt = pend[$] + 1;
            pend.push_back(dt);
            l = dt - s;
            elast = l;
            if (l < emin) emin = l;
            if (l > emax) emax = l;
            outst++;
            if (outst > maxo) maxo = outst;
            wcnt = 0;
            after_rdy = 1;
            zr = 0;
         end else begin
            wcnt++;
            waiting = 1;
         end
      end
   endtask

   task automatic run(input int num, input int gap, input int rdy, input int lo, input int hi,
                      input string tag);
      int n;
      model_clear(rdy, lo, hi);
      cfg_num_txn_i = 16'(num);
      cfg_gap_i = 8'(gap);
      cfg_start_i = 1'b1;
      step();
      cfg_start_i = 1'b0;
      n = 0;
      while (!finish_o && n < 3000) begin
         step();
         n++;
      end
      check({tag, "_finished"}, finish_o, 1'b1);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_issued"}, txn_issued_o, 64'(num));
      check({tag, "_done"}, txn_done_o, 64'(num));
      check({tag, "_lat_min"}, lat_min_o, emin);
      check({tag, "_lat_max"}, lat_max_o, emax);
      check({tag, "_lat_last"}, lat_last_o, elast);
      check({tag, "_err_spurious"}, err_spurious_o, 1'b0);
      check({tag, "_err_timeout"}, err_timeout_o, 1'b0);
      check({tag, "_start_held"}, 64'(drop_err), 64'd0);
      check({tag, "_max_outstanding"}, maxo <= 4, 1'b1);
   endtask

   initial begin
      int n;
      model_clear(0, 1, 1);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_ap_start", ap_start_o, 1'b0);
      check("rst_ap_continue", ap_continue_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_finish", finish_o, 1'b0);
      check("rst_lat_min", lat_min_o, 64'hFFFF_FFFF);
      check("rst_lat_max", lat_max_o, 64'd0);
      check("rst_issued", txn_issued_o, 64'd0);
      step();
      step();
      rst_ni = 1'b1;
      step();
      check("continue_after_reset", ap_continue_o, 1'b1);

      run(5, 0, 0, 3, 3, "b2b");
      check("b2b_gap_max", 64'(gmax), 64'd0);
      check("b2b_gap_min", 64'(gmin), 64'd0);

      run(8, 0, 4, 10, 10, "slow");
      run(10, 0, 0, 12, 16, "full");
      check("full_reached_max_out", 64'(maxo), 64'd4);

      run(3, 5, 0, 3, 3, "gap");
      check("gap_min", 64'(gmin), 64'd5);
      check("gap_max", 64'(gmax), 64'd5);

      for (int r = 0; r < 4; r++)
         run(int'($urandom_range(12, 6)), int'($urandom_range(3, 0)),
             int'($urandom_range(3, 0)), 1, 20, "rand");

      model_clear(0, 1, 1);
      cfg_num_txn_i = 16'd0;
      cfg_start_i = 1'b1;
      step();
      cfg_start_i = 1'b0;
      check("zero_finish_cycle1", finish_o, 1'b0);
      step();
      check("zero_finish_cycle2", finish_o, 1'b1);
      check("zero_no_start", 64'(started), 64'd0);
      check("zero_issued", txn_issued_o, 64'd0);

      step();
      ap_done_i = 1'b1;
      step();
      check("spurious_flag", err_spurious_o, 1'b1);
      check("spurious_done_cnt", txn_done_o, 64'd0);
      run(2, 0, 1, 4, 6, "after_spurious");

      model_clear(1000, 1, 1);
      cfg_num_txn_i = 16'd2;
      cfg_start_i = 1'b1;
      step();
      cfg_start_i = 1'b0;
      repeat (63) step();
      check("timeout_not_yet", err_timeout_o, 1'b0);
      check("timeout_start_held", ap_start_o, 1'b1);
      step();
      check("timeout_flag", err_timeout_o, 1'b1);
      check("timeout_start_low", ap_start_o, 1'b0);
      check("timeout_busy_low", busy_o, 1'b0);
      step();
      check("timeout_finish", finish_o, 1'b1);
      check("timeout_issued", txn_issued_o, 64'd0);

      run(3, 1, 0, 2, 5, "after_timeout");

      model_clear(0, 20, 20);
      cfg_num_txn_i = 16'd4;
      cfg_start_i = 1'b1;
      step();
      cfg_start_i = 1'b0;
      n = 0;
      while (txn_issued_o != 16'd4 && n < 100) begin
         step();
         n++;
      end
      step();
      check("drain_busy", busy_o, 1'b1);
      check("drain_issued", txn_issued_o, 64'd4);
      rst_ni = 1'b0;
      #1;
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_issued", txn_issued_o, 64'd0);
      check("midrst_done", txn_done_o, 64'd0);
      check("midrst_lat_min", lat_min_o, 64'hFFFF_FFFF);
      check("midrst_lat_last", lat_last_o, 64'd0);
      check("midrst_continue", ap_continue_o, 1'b0);
      pend.delete();
      step();
      rst_ni = 1'b1;
      step();
      run(2, 0, 0, 3, 7, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
